// File: rtl/tdm_demux_rx_pkg.sv
// Constants and FSM encoding for the TDM link. The matching transmitter uses
// the same package.
package tdm_demux_rx_pkg;

    localparam int TDM_NUM_CH = 4;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_t;

endpackage

// File: rtl/tdm_demux_rx.sv
// TDM frame receiver. It collects four slot beats per frame into a shadow
// buffer and publishes them only when the whole frame has arrived.
module tdm_demux_rx
    import tdm_demux_rx_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int NUM_CH = TDM_NUM_CH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             valid,
    input  logic             frame_start,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] ch0,
    output logic [WIDTH-1:0] ch1,
    output logic [WIDTH-1:0] ch2,
    output logic [WIDTH-1:0] ch3,
    output logic             frame_done,
    output logic             sync_err,
    output logic             locked,
    output logic [7:0]       frame_count
);

    localparam logic [1:0] LAST_SLOT = 2'(NUM_CH - 1);

    tdm_state_t       state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [WIDTH-1:0] shadow_q [NUM_CH-1];
    logic [WIDTH-1:0] shadow_d [NUM_CH-1];
    logic [WIDTH-1:0] ch_q [NUM_CH];
    logic [WIDTH-1:0] ch_d [NUM_CH];
    logic             frame_done_q, frame_done_d;
    logic             sync_err_q, sync_err_d;
    logic [7:0]       count_q, count_d;
    logic             wr_en;
    logic [1:0]       wr_idx;

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        shadow_d     = shadow_q;
        ch_d         = ch_q;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;
        count_d      = count_q;
        wr_en        = 1'b0;
        wr_idx       = 2'd0;

        if (enable && valid) begin
            case (state_q)
                HUNT: begin
                    if (frame_start) begin
                        wr_en   = 1'b1;
                        slot_d  = 2'd1;
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_start) begin
                        // A frame start anywhere but slot 0 aborts the partial frame and restarts it.
                        sync_err_d = (slot_q != 2'd0);
                        wr_en      = 1'b1;
                        slot_d     = 2'd1;
                    end else if (slot_q == 2'd0) begin
                        sync_err_d = 1'b1;
                        state_d    = HUNT;
                    end else if (slot_q == LAST_SLOT) begin
                        for (int i = 0; i < NUM_CH - 1; i++) begin
                            ch_d[i] = shadow_q[i];
                        end
                        ch_d[NUM_CH-1] = data_in;
                        frame_done_d   = 1'b1;
                        count_d        = count_q + 8'd1;
                        slot_d         = 2'd0;
                    end else begin
                        wr_en  = 1'b1;
                        wr_idx = slot_q;
                        slot_d = slot_q + 2'd1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        for (int i = 0; i < NUM_CH - 1; i++) begin
            if (wr_en && (wr_idx == 2'(i))) begin
                shadow_d[i] = data_in;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= HUNT;
            slot_q       <= 2'd0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
            count_q      <= 8'd0;
            for (int i = 0; i < NUM_CH - 1; i++) begin
                shadow_q[i] <= '0;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                ch_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
            count_q      <= count_d;
            shadow_q     <= shadow_d;
            ch_q         <= ch_d;
        end
    end

    assign ch0         = ch_q[0];
    assign ch1         = ch_q[1];
    assign ch2         = ch_q[2];
    assign ch3         = ch_q[3];
    assign frame_done  = frame_done_q;
    assign sync_err    = sync_err_q;
    assign locked      = (state_q == LOCKED);
    assign frame_count = count_q;

endmodule

// File: tb/tb_tdm_demux_rx.sv
// Scoreboard bench for tdm_demux_rx. Stimulus queues the expected frame and
// sync-error events, and a negedge monitor consumes them as the DUT reports.
module tb_tdm_demux_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       valid = 1'b0;
    logic       frame_start = 1'b0;
    logic [3:0] data_in = 4'd0;
    logic [3:0] ch0, ch1, ch2, ch3;
    logic       frame_done, sync_err, locked;
    logic [7:0] frame_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         is_frame;
        logic [3:0] c0, c1, c2, c3;
        logic [7:0] cnt;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] exp_count = 8'd0;

    tdm_demux_rx #(.WIDTH(4), .NUM_CH(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .valid(valid),
        .frame_start(frame_start), .data_in(data_in),
        .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
        .frame_done(frame_done), .sync_err(sync_err), .locked(locked),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every reported event must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        chk("excl_done_err", 32'(frame_done & sync_err), 32'd0);
        if (frame_done || sync_err) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", 32'({frame_done, sync_err}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("event_kind", 32'({frame_done, sync_err}), e.is_frame ? 32'd2 : 32'd1);
                if (e.is_frame) begin
                    chk("ch0", 32'(ch0), 32'(e.c0));
                    chk("ch1", 32'(ch1), 32'(e.c1));
                    chk("ch2", 32'(ch2), 32'(e.c2));
                    chk("ch3", 32'(ch3), 32'(e.c3));
                    chk("frame_count", 32'(frame_count), 32'(e.cnt));
                    $display("frame ch=%h %h %h %h count=%0d", ch0, ch1, ch2, ch3, frame_count);
                end else begin
                    $display("sync_err event locked=%0b", locked);
                end
            end
        end
    end

    task automatic push_frame(input logic [3:0] a, b, c, d);
        exp_t e;
        exp_count = exp_count + 8'd1;
        e.is_frame = 1'b1;
        e.c0 = a; e.c1 = b; e.c2 = c; e.c3 = d; e.cnt = exp_count;
        exp_q.push_back(e);
    endtask

    task automatic push_sync();
        exp_t e;
        e.is_frame = 1'b0;
        e.c0 = '0; e.c1 = '0; e.c2 = '0; e.c3 = '0; e.cnt = '0;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; the beat is taken at the next posedge and the task
    // returns on the negedge after it.
    task automatic send(input logic [3:0] d, input logic fs);
        data_in     = d;
        valid       = 1'b1;
        frame_start = fs;
        @(negedge clk);
        valid       = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic full_frame(input logic [3:0] a, b, c, d);
        send(a, 1'b1);
        send(b, 1'b0);
        send(c, 1'b0);
        push_frame(a, b, c, d);
        send(d, 1'b0);
    endtask

    task automatic chk_ch(input string name, input logic [3:0] a, b, c, d);
        chk(name, 32'({ch0, ch1, ch2, ch3}), 32'({a, b, c, d}));
    endtask

    initial begin
        idle(2);
        chk_ch("reset_ch", 4'h0, 4'h0, 4'h0, 4'h0);
        chk("reset_locked", 32'(locked), 32'd0);
        chk("reset_count", 32'(frame_count), 32'd0);
        reset = 1'b0;
        idle(1);

        // Basic frame
        full_frame(4'hA, 4'hB, 4'hC, 4'hD);
        chk("locked_after_frame", 32'(locked), 32'd1);
        chk("count_after_frame", 32'(frame_count), 32'd1);
        idle(2);

        // Early frame_start on the third beat
        send(4'h1, 1'b1);
        send(4'h2, 1'b0);
        push_sync();
        send(4'h9, 1'b1);
        chk_ch("held_after_resync", 4'hA, 4'hB, 4'hC, 4'hD);
        send(4'h8, 1'b0);
        send(4'h7, 1'b0);
        push_frame(4'h9, 4'h8, 4'h7, 4'h6);
        send(4'h6, 1'b0);
        chk("locked_after_resync", 32'(locked), 32'd1);

        // Missing frame_start at slot 0 drops lock
        push_sync();
        send(4'hF, 1'b0);
        chk("unlocked_after_miss", 32'(locked), 32'd0);
        chk_ch("held_after_miss", 4'h9, 4'h8, 4'h7, 4'h6);

        // Hunt discards beats without frame_start
        send(4'h5, 1'b0);
        send(4'h6, 1'b0);
        chk("still_hunting", 32'(locked), 32'd0);
        full_frame(4'h1, 4'h2, 4'h3, 4'h4);

        // Enable stall with garbage on the inputs, plus valid gaps
        send(4'h2, 1'b1);
        idle(1);
        send(4'h5, 1'b0);
        enable = 1'b0;
        data_in = 4'hF; valid = 1'b1; frame_start = 1'b1;
        idle(3);
        valid = 1'b0; frame_start = 1'b0;
        enable = 1'b1;
        send(4'hC, 1'b0);
        idle(2);
        push_frame(4'h2, 4'h5, 4'hC, 4'h1);
        send(4'h1, 1'b0);

        // Asynchronous reset mid-frame
        send(4'h3, 1'b1);
        send(4'h4, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk_ch("async_reset_ch", 4'h0, 4'h0, 4'h0, 4'h0);
        chk("async_reset_locked", 32'(locked), 32'd0);
        chk("async_reset_count", 32'(frame_count), 32'd0);
        exp_count = 8'd0;
        @(negedge clk);
        reset = 1'b0;
        send(4'h1, 1'b0);
        send(4'h2, 1'b0);
        send(4'h3, 1'b0);
        send(4'h4, 1'b0);
        chk_ch("post_reset_ignored", 4'h0, 4'h0, 4'h0, 4'h0);
        chk("post_reset_locked", 32'(locked), 32'd0);

        // 256 frames wrap the counter back to 0
        for (int i = 0; i < 256; i++) begin
            full_frame(4'(i), 4'(i + 3), 4'(~i), 4'(i * 5));
        end
        chk("count_wrapped", 32'(frame_count), 32'd0);

        idle(4);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
